// File: rtl/axis_pkg.sv
// axis_pkg: types and helpers shared by the AXI-stream round-robin arbiter.
//   state_t     : arbiter FSM state encoding (IDLE = 0, GRANT = 1)
//   clog2       : ceiling log2, usable in constant expressions
//   burst_cnt_w : width of the beat counter for a given burst length
package axis_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // One extra bit so the counter can represent MAX_BURST itself.
  function automatic int burst_cnt_w(input int max_burst);
    return clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: stateless round-robin winner search.
// The search starts one past last_idx and ascends with wrap; the first set
// request bit wins.
//   req        : request vector (N bits)
//   last_idx   : index of the most recently granted requester
//   win_onehot : one-hot winner, all-zero when nothing is requested
//   win_idx    : binary index of the winner
//   any        : at least one request is set
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  output logic [N-1:0]  win_onehot,
  output logic [IW-1:0] win_idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    any        = 1'b0;
    cand       = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_idx) + k) % N);
      if (!any && req[cand]) begin
        win_onehot[cand] = 1'b1;
        win_idx          = cand;
        any              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: round-robin arbiter for AXI-stream sources with burst
// hold. The grant is registered, held without preemption, and handed to the
// next winner on the releasing edge with no idle bubble.
//   clk_i       : clock
//   rst_n_i     : asynchronous active-low reset
//   s_axi_vld_i : per-source valid, used as the request vector
//   m_axi_rdy_i : downstream ready, qualifies completed beats
//   grant_o     : one-hot (or zero) grant to the downstream mux
//   busy_o      : registered OR of grant_o
// Build option: AXIS_RR_ARBITER_BURST_EN -- when defined, a grant is held
// for up to MAX_BURST beats; otherwise every grant releases after one beat.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | no grant held, waiting for any request
// ST_GRANT | one port granted, counting beats until release
module axis_rr_arbiter
  import axis_pkg::*;
#(
  parameter int PORT_NUM  = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [PORT_NUM-1:0] s_axi_vld_i,
  input  logic                m_axi_rdy_i,
  output logic [PORT_NUM-1:0] grant_o,
  output logic                busy_o
);

  localparam int IW = clog2(PORT_NUM);

  if (PORT_NUM < 2 || MAX_BURST < 1) begin : g_bad_param
    $error("axis_rr_arbiter: PORT_NUM must be >= 2 and MAX_BURST >= 1");
  end

  state_t              state;
  logic [IW-1:0]       last_grant;
  logic [PORT_NUM-1:0] pick_onehot;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic                cur_vld;
  logic                beat;
  logic                rel;

  rr_pick #(
    .N  (PORT_NUM),
    .IW (IW)
  ) u_pick (
    .req        (s_axi_vld_i),
    .last_idx   (last_grant),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .any        (pick_any)
  );

  // last_grant always names the currently held port while in ST_GRANT.
  assign cur_vld = (state == ST_GRANT) && s_axi_vld_i[last_grant];
  assign beat    = cur_vld && m_axi_rdy_i;

`ifdef AXIS_RR_ARBITER_BURST_EN
  localparam int CW = burst_cnt_w(MAX_BURST);

  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] cnt_nxt;

  assign cnt_nxt = beat_cnt + CW'(1);
  assign rel     = !cur_vld || (beat && (cnt_nxt == CW'(MAX_BURST)));

  // Cleared on every release (and while idle, where rel is trivially high),
  // so each newly loaded grant starts from zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      beat_cnt <= '0;
    end else if (rel) begin
      beat_cnt <= '0;
    end else if (beat) begin
      beat_cnt <= cnt_nxt;
    end
  end
`else
  assign rel = !cur_vld || beat;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= ST_IDLE;
      grant_o    <= '0;
      busy_o     <= 1'b0;
      last_grant <= IW'(PORT_NUM - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state      <= ST_GRANT;
            grant_o    <= pick_onehot;
            busy_o     <= 1'b1;
            last_grant <= pick_idx;
          end
        end
        ST_GRANT: begin
          if (rel) begin
            // The released port competes normally: it only wins again when
            // it is still requesting and nobody after it in the ring is.
            if (pick_any) begin
              grant_o    <= pick_onehot;
              last_grant <= pick_idx;
            end else begin
              state   <= ST_IDLE;
              grant_o <= '0;
              busy_o  <= 1'b0;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant_o <= '0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 SHALL have parameter PORT_NUM, default 4: number of requesting AXI-stream sources; must be >= 2.
REQ-002 SHALL have parameter MAX_BURST, default 4: beats granted to one port before rotating; must be >= 1.
REQ-003 SHALL have port clk_i, input, 1: single clock, all state on the rising edge.
REQ-004 SHALL have port rst_n_i, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port s_axi_vld_i, input, PORT_NUM: per-source valid, used as the request vector.
REQ-006 SHALL have port m_axi_rdy_i, input, 1: downstream ready, used to detect completed beats.
REQ-007 SHALL have port grant_o, output, PORT_NUM: one-hot or all-zero grant, driving the downstream mux control input.
REQ-008 SHALL have port busy_o, output, 1: high while any grant is held.

Function
REQ-009 SHALL implement a two-state FSM: IDLE (grant_o = 0) and GRANT (exactly one grant_o bit set).
REQ-010 SHALL define a beat as s_axi_vld_i[g] & m_axi_rdy_i in a cycle where g is the granted port.
REQ-011 In IDLE with any s_axi_vld_i bit set, SHALL register the round-robin winner into grant_o at the next edge (1-cycle latency) and enter GRANT.
REQ-012 Round-robin search SHALL start at index last_grant+1 mod PORT_NUM and ascend with wrap; the first set request wins.
REQ-013 Held grant SHALL stay constant until release; no preemption by other requests.
REQ-014 A beat counter SHALL increment on each beat; width SHALL be clog2(MAX_BURST)+1 bits, no overflow.
REQ-015 Release SHALL occur on the beat that makes count equal MAX_BURST, or in any cycle where s_axi_vld_i[g] is low.
REQ-016 On release with other requests pending, the next winner SHALL load at the same edge: zero bubble, stay in GRANT, counter cleared.
REQ-017 On release with the released port as the only requester, that port SHALL be re-granted with a fresh count.
REQ-018 On release with no requests pending, SHALL go to IDLE with grant_o = 0 at the next edge.
REQ-019 last_grant SHALL update only when a new grant loads.
REQ-020 busy_o SHALL equal |grant_o, registered, and SHALL never glitch between back-to-back grants.

Reset
REQ-021 Asserting rst_n_i SHALL immediately force: grant_o = 0, busy_o = 0, state IDLE, counter 0, last_grant = PORT_NUM-1 (port 0 has first priority).
REQ-022 Reset mid-burst SHALL drop the grant with no completion; the first arbitration after deassertion SHALL follow REQ-021 priority.

Configuration
REQ-023 Macro AXIS_RR_ARBITER_BURST_EN: when defined, SHALL behave as REQ-014/REQ-015 with MAX_BURST.
REQ-024 Without AXIS_RR_ARBITER_BURST_EN: counter SHALL be removed, each grant SHALL release after exactly one beat (MAX_BURST ignored), and all other behaviour SHALL be unchanged.

Structure
REQ-025 The shared package axis_pkg SHALL hold the FSM state encoding (IDLE = 0, GRANT = 1) and the clog2 width helper.
REQ-026 The round-robin selection SHALL be a combinational sub-module rr_pick (inputs: request vector, last_grant index; outputs: one-hot winner, winner index, any).
REQ-027 All registers SHALL reside in axis_rr_arbiter; rr_pick SHALL be stateless.

Verification (PORT_NUM = 4, MAX_BURST = 4, burst macro defined unless noted)
REQ-028 Reset then s_axi_vld_i = 4'b1111, m_axi_rdy_i = 1 constant -> grant_o sequence 0001, 0010, 0100, 1000, 0001, each held exactly 4 cycles, no zero cycles between.
REQ-029 s_axi_vld_i = 4'b0100 only, m_axi_rdy_i toggling 1,0,1,0,... -> grant_o = 0100 held through 4 beats (7 cycles), then re-granted 0100.
REQ-030 Port 1 granted, its vld drops after 2 beats while s_axi_vld_i[3] = 1 -> grant_o = 1000 at the next edge, counter restarts at 0.
REQ-031 s_axi_vld_i goes 0 after the final beat of port 2 -> grant_o = 0000 and busy_o = 0 next cycle; later vld 4'b0011 -> grant_o = 0001 (search starts at index 3).
REQ-032 rst_n_i pulsed low during beat 2 of port 3 -> grant_o = 0000 asynchronously; after release with vld 4'b1010 -> grant_o = 0010.
REQ-033 Macro undefined, vld 4'b1111, rdy 1 -> grant rotates 0001, 0010, 0100, 1000 every cycle.
